// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one shared combinational ALU and holds each response until consumed
// Optional feature macro: ALU_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority (requester 0 first).
// Ports:
//     clk, rst                        clock, asynchronous active-high reset
//     req_valid / req_ready           per-requester handshake, bit i belongs to requester i
//     req_a0/b0/op0, req_a1/b1/op1    operands and opcode of requester 0 / 1
//     alu_a / alu_b / alu_op          shared ALU inputs, idle values outside EXEC
//     alu_result / alu_zero           combinational ALU return path
//     resp_valid/id/result/zero       registered response, held until resp_ready
//     resp_ready                      consumer takes the response this cycle
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef ALU_OPCODE
`define ALU_OPCODE 3:0
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'h1
`endif
`ifndef ALU_AND
`define ALU_AND 4'h2
`endif
`ifndef ALU_DEFAULT
`define ALU_DEFAULT 4'h0
`endif

module alu_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    input  logic [`DATA_LEN-1:0] req_a0,
    input  logic [`DATA_LEN-1:0] req_b0,
    input  logic [`ALU_OPCODE]   req_op0,
    input  logic [`DATA_LEN-1:0] req_a1,
    input  logic [`DATA_LEN-1:0] req_b1,
    input  logic [`ALU_OPCODE]   req_op1,
    output logic [1:0]           req_ready,
    output logic [`DATA_LEN-1:0] alu_a,
    output logic [`DATA_LEN-1:0] alu_b,
    output logic [`ALU_OPCODE]   alu_op,
    input  logic [`DATA_LEN-1:0] alu_result,
    input  logic                 alu_zero,
    output logic                 resp_valid,
    output logic                 resp_id,
    output logic [`DATA_LEN-1:0] resp_result,
    output logic                 resp_zero,
    input  logic                 resp_ready
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state_q, state_d;
    logic [`DATA_LEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [`ALU_OPCODE] op_q, op_d;
    logic id_q, id_d, valid_q, valid_d, zero_q, zero_d, rid_q, rid_d;
    logic grant, accept;
`ifdef ALU_ARB_RR_EN
    logic last_q, last_d;
    // on contention the requester not served last wins; a lone requester always wins
    assign grant = &req_valid ? ~last_q : req_valid[1];
`else
    assign grant = ~req_valid[0];
`endif
    // gated by rst so no handshake is offered while reset is held
    assign accept = state_q == IDLE && |req_valid && !rst;
    assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign alu_a = state_q == EXEC ? a_q : '0;
    assign alu_b = state_q == EXEC ? b_q : '0;
    assign alu_op = state_q == EXEC ? op_q : `ALU_DEFAULT;
    assign resp_valid = valid_q;
    assign resp_id = rid_q;
    assign resp_result = result_q;
    assign resp_zero = zero_q;

    always_comb begin
        state_d = state_q == IDLE ? (accept ? EXEC : IDLE) :
                  state_q == EXEC ? RESP : (resp_ready ? IDLE : RESP);
        a_d = accept ? (grant ? req_a1 : req_a0) : a_q;
        b_d = accept ? (grant ? req_b1 : req_b0) : b_q;
        op_d = accept ? (grant ? req_op1 : req_op0) : op_q;
        id_d = accept ? grant : id_q;
        result_d = state_q == EXEC ? alu_result : result_q;
        zero_d = state_q == EXEC ? alu_zero : zero_q;
        rid_d = state_q == EXEC ? id_q : rid_q;
        valid_d = state_q == EXEC ? 1'b1 : (state_q == RESP && resp_ready) ? 1'b0 : valid_q;
`ifdef ALU_ARB_RR_EN
        last_d = accept ? grant : last_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            id_q <= 1'b0;
            result_q <= '0;
            zero_q <= 1'b0;
            rid_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            op_q <= op_d;
            id_q <= id_d;
            result_q <= result_d;
            zero_q <= zero_d;
            rid_q <= rid_d;
            valid_q <= valid_d;
`ifdef ALU_ARB_RR_EN
            last_q <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural shared ALU
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef ALU_OPCODE
`define ALU_OPCODE 3:0
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'h1
`endif
`ifndef ALU_AND
`define ALU_AND 4'h2
`endif
`ifndef ALU_DEFAULT
`define ALU_DEFAULT 4'h0
`endif

module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [`DATA_LEN-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [`ALU_OPCODE] req_op0 = `ALU_ADD, req_op1 = `ALU_ADD;
    logic [`DATA_LEN-1:0] alu_a, alu_b, alu_result, resp_result;
    logic [`ALU_OPCODE] alu_op;
    logic alu_zero, resp_valid, resp_id, resp_zero;
    logic resp_ready = 1'b1;

    typedef struct packed {
        logic id;
        logic [`DATA_LEN-1:0] res;
        logic zero;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    alu_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_zero(resp_zero), .resp_ready(resp_ready)
    );

    function automatic logic [`DATA_LEN-1:0] alu_f(input logic [`DATA_LEN-1:0] a, input logic [`DATA_LEN-1:0] b, input logic [`ALU_OPCODE] op);
        return op == `ALU_ADD ? a + b : op == `ALU_SUB ? a - b : op == `ALU_AND ? a & b : a | b;
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);
    assign alu_zero = alu_result == '0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL %s_sb: observed unexpected response, expected none pending", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_id"}, 32'(resp_id), 32'(e.id));
            chk({tag, "_res"}, resp_result, e.res);
            chk({tag, "_zero"}, 32'(resp_zero), 32'(e.zero));
        end
    endtask

    // called on the negedge before the accepting edge; returns on the negedge inside EXEC
    task automatic issue(input string tag, input logic [1:0] v, input logic [1:0] exp_rdy, input exp_t e);
        req_valid = v;
        #1;
        chk({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
        sb.push_back(e);
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    // waits for the response, checks it, then checks it clears once taken
    task automatic drain(input string tag, input int exp_lat);
        int n = 0;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        if (resp_valid) pop_chk(tag);
        @(negedge clk);
        #1;
        chk({tag, "_clr"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int acc = 0, cyc = 0, last_cyc = 0;
        logic pend = 1'b0, pid = 1'b0, id;
        req_valid = 2'b01;
        req_a0 = 32'h1234;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'(`ALU_DEFAULT));
        req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);

        req_a0 = 32'd5; req_b0 = 32'd3; req_op0 = `ALU_ADD;
        issue("add", 2'b01, 2'b01, '{1'b0, 32'd8, 1'b0});
        #1;
        chk("add_exec_a", alu_a, 32'd5);
        chk("add_exec_b", alu_b, 32'd3);
        chk("add_exec_op", 32'(alu_op), 32'(`ALU_ADD));
        chk("add_exec_rdy", 32'(req_ready), 32'd0);
        drain("add", 1);
        chk("idle_alu_b", alu_b, 32'd0);

        req_a1 = 32'd7; req_b1 = 32'd7; req_op1 = `ALU_SUB;
        issue("zero", 2'b10, 2'b10, '{1'b1, 32'd0, 1'b1});
        drain("zero", 1);

        req_a0 = 32'd100; req_b0 = 32'd1; req_op0 = `ALU_ADD;
        req_a1 = 32'd50; req_b1 = 32'd20; req_op1 = `ALU_SUB;
        req_valid = 2'b11;
        while ((acc < 4 || sb.size() != 0) && cyc < 40) begin
            #1;
            if (resp_valid) pop_chk("cont");
            if (req_ready != 2'b00) begin
`ifdef ALU_ARB_RR_EN
                id = acc[0];
`else
                id = 1'b0;
`endif
                chk("cont_grant", 32'(req_ready), id ? 32'd2 : 32'd1);
                if (acc > 0) chk("cont_gap", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                sb.push_back(id ? '{1'b1, alu_f(req_a1, req_b1, req_op1), alu_f(req_a1, req_b1, req_op1) == '0}
                                : '{1'b0, alu_f(req_a0, req_b0, req_op0), alu_f(req_a0, req_b0, req_op0) == '0});
                pend = 1'b1;
                pid = id;
                acc++;
            end
            @(negedge clk);
            cyc++;
            if (pend) begin
                pend = 1'b0;
                if (pid) req_a1 = req_a1 + 32'd7;
                else req_a0 = req_a0 + 32'd3;
                if (acc == 4) req_valid = 2'b00;
            end
        end
        chk("cont_accepts", 32'(acc), 32'd4);

        resp_ready = 1'b0;
        req_a0 = 32'd10; req_b0 = 32'd4; req_op0 = `ALU_SUB;
        issue("bp", 2'b01, 2'b01, '{1'b0, 32'd6, 1'b0});
        req_a1 = 32'd3; req_b1 = 32'd4; req_op1 = `ALU_ADD;
        req_valid = 2'b10;
        #1;
        chk("bp_exec_rdy", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("bp_rise", 32'(resp_valid), 32'd1);
        pop_chk("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_res", resp_result, 32'd6);
            chk("bp_hold_rdy", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_clr", 32'(resp_valid), 32'd0);
        chk("bp_keep_res", resp_result, 32'd6);
        issue("bp2", 2'b10, 2'b10, '{1'b1, 32'd7, 1'b0});
        drain("bp2", 1);

        req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1; req_op0 = `ALU_AND;
        req_valid = 2'b01;
        #1;
        chk("rmid_acc_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rmid_valid", 32'(resp_valid), 32'd0);
        chk("rmid_result", resp_result, 32'd0);
        chk("rmid_rdy", 32'(req_ready), 32'd0);
        chk("rmid_alu_a", alu_a, 32'd0);
        @(negedge clk);
        chk("rmid_no_resp", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        issue("rerun", 2'b01, 2'b01, '{1'b0, 32'd1, 1'b0});
        drain("rerun", 1);

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_empty: observed %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; operand width is `DATA_LEN (32) and opcode width is the `ALU_OPCODE range, both taken from defines.v.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_a0, req_b0 / req_a1, req_b1  input  `DATA_LEN each  operands of requester 0 / 1.
REQ-006 req_op0 / req_op1  input  `ALU_OPCODE  opcode of requester 0 / 1.
REQ-007 req_ready  output  2  per-requester accept strobe.
REQ-008 alu_a, alu_b  output  `DATA_LEN  operands driven to the shared ALU.
REQ-009 alu_op  output  `ALU_OPCODE  opcode driven to the shared ALU.
REQ-010 alu_result  input  `DATA_LEN  combinational result returned by the shared ALU.
REQ-011 alu_zero  input  1  zero flag returned by the shared ALU.
REQ-012 resp_valid  output  1  the response registers hold a completed operation.
REQ-013 resp_id  output  1  index of the requester that owns the response.
REQ-014 resp_result  output  `DATA_LEN  captured ALU result.
REQ-015 resp_zero  output  1  captured zero flag.
REQ-016 resp_ready  input  1  the consumer takes the response this cycle.

Function
REQ-017 The FSM SHALL have three states:
- IDLE: accept a request.
- EXEC: drive the ALU.
- RESP: hold the response.
REQ-018 In IDLE, if any req_valid bit is set, the arbiter SHALL select a grant index, and req_ready[grant] SHALL be 1 combinationally; the other bit SHALL be 0.
REQ-019 req_ready SHALL be 2'b00 in EXEC and RESP, and in IDLE when req_valid == 2'b00.
REQ-020 An accept is req_valid[i] && req_ready[i]. On an accept the block SHALL latch that requester's a, b and op and the index i, then move to EXEC.
REQ-021 A requester SHALL hold its operands stable while req_valid is high and it has not been accepted.
REQ-022 In EXEC, alu_a, alu_b and alu_op SHALL equal the latched values. At the clock edge the block SHALL capture alu_result and alu_zero into resp_result and resp_zero, set resp_valid = 1 and resp_id = latched index, and move to RESP.
REQ-023 Outside EXEC, alu_a and alu_b SHALL be 0 and alu_op SHALL be `ALU_DEFAULT.
REQ-024 In RESP, resp_valid, resp_id, resp_result and resp_zero SHALL hold stable until resp_ready = 1.
REQ-025 On RESP && resp_ready, resp_valid SHALL clear at the next edge and the state SHALL return to IDLE; resp_result, resp_zero and resp_id keep their last values.
REQ-026 Timing:
- Latency: accept at edge N gives resp_valid = 1 after edge N+1.
- Minimum request-to-request spacing is 3 cycles.
REQ-027 A requester whose req_valid rises while the block is in EXEC or RESP SHALL wait without loss; it is considered in the next IDLE cycle.
REQ-028 When both req_valid bits are set in the same IDLE cycle, exactly one SHALL be granted per REQ-033/034; the loser keeps waiting.
REQ-029 resp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-030 On rst = 1, asynchronously and regardless of state, the block SHALL:
- go to IDLE;
- clear resp_valid, resp_id, resp_result and resp_zero to 0;
- clear the latched operands and index to 0;
- set the round-robin pointer last_grant = 1.
REQ-031 An operation in flight at reset SHALL be discarded with no response. Requesters re-present it by keeping req_valid high.
REQ-032 While rst = 1, req_ready SHALL be 2'b00 and the ALU ports SHALL be at their idle values (REQ-023).

Configuration
REQ-033 With macro ALU_ARB_RR_EN defined:
- Arbitration is round-robin: when both requests are valid, grant = ~last_grant.
- When only one request is valid, it is granted.
- last_grant updates to the granted index on every accept.
REQ-034 Without ALU_ARB_RR_EN:
- Arbitration is fixed priority: requester 0 wins whenever req_valid[0] = 1.
- last_grant is not implemented.

Verification
REQ-035 Single op: req_valid = 2'b01, a0 = 5, b0 = 3, op0 = `ALU_ADD, resp_ready = 1 -> req_ready = 2'b01 in the first cycle; 2 cycles later resp_valid = 1, resp_id = 0, resp_result = 8, resp_zero = 0.
REQ-036 Zero flag: requester 1 sends a1 = 7, b1 = 7, op1 = `ALU_SUB -> resp_id = 1, resp_result = 0, resp_zero = 1.
REQ-037 Contention with ALU_ARB_RR_EN: both requesters valid continuously, resp_ready = 1 -> grant order 0, 1, 0, 1, one accept every 3 cycles. Without the macro, requester 0 is granted every time.
REQ-038 Backpressure: resp_ready = 0 for 5 cycles after resp_valid rises -> resp_valid and resp_result stay stable, req_ready = 2'b00 throughout, and the next accept happens in the cycle after IDLE is re-entered.
REQ-039 Reset mid-EXEC: assert rst in the cycle after an accept of a0 = 0xFFFFFFFF, b0 = 1, op0 = `ALU_AND -> resp_valid = 0 immediately and no response appears. After rst deasserts, with req_valid held, the op is re-accepted and gives resp_result = 1.
